spi_pkg_ctrl: RTL and testbench

- Package-level transfer controller between the DAQ-side FIFO and the SPI slave that feeds the WiFi host.
- Waits until one full package is buffered, then runs pre-delay and raises the host interrupt.
- During the chip-select window it paces FIFO reads from the slave's byte requests, then runs post-delay.
- Keeps package alignment on aborted or short transfers and reports sticky errors.

---
 rtl/spi_pkg_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_spi_pkg_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pkg_ctrl.sv
// spi_pkg_ctrl: package-level transfer controller between the DAQ FIFO and the
// SPI slave feeding the WiFi host. Waits for one full package, runs a pre-delay,
// raises the host interrupt, paces FIFO reads from slave byte requests inside the
// chip-select window, drains the remainder of short transfers so the FIFO stays
// package-aligned, then runs a post-delay.
// Build option: define SPI_PKG_CNT_EN to implement the 16-bit completed-package
// counter; otherwise pkg_cnt is tied to zero (port list unchanged).
module spi_pkg_ctrl #(
    parameter int PACKAGE_SIZE = 2000,
    parameter int LEVEL_WIDTH  = 12,
    parameter int PRE_DELAY    = 16,
    parameter int POS_DELAY    = 16,
    parameter int CS_TIMEOUT   = 50000
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   en,
    input  logic [LEVEL_WIDTH-1:0] fifo_level,
    input  logic                   fifo_empty,
    input  logic                   cs_n,
    input  logic                   byte_req,
    input  logic                   err_clr,
    output logic                   fifo_rd_en,
    output logic                   intr_out,
    output logic                   package_ready,
    output logic                   pre_delay_flag,
    output logic                   pos_delay_flag,
    output logic                   busy,
    output logic [3:0]             err_flags,
    output logic [15:0]            pkg_cnt,
    output logic [2:0]             state_dbg
);

    localparam int BW      = $clog2(PACKAGE_SIZE + 1);
    localparam int DLY_MAX = (PRE_DELAY > POS_DELAY) ? PRE_DELAY : POS_DELAY;
    localparam int DW      = $clog2(DLY_MAX + 1);
    localparam int TW      = $clog2(CS_TIMEOUT + 1);

    localparam logic [BW-1:0]          PKG_BYTES = BW'(PACKAGE_SIZE);
    localparam logic [BW-1:0]          BYTE_ONE  = BW'(1);
    localparam logic [LEVEL_WIDTH-1:0] PKG_LEVEL = LEVEL_WIDTH'(PACKAGE_SIZE);
    localparam logic [DW-1:0]          DLY_ONE   = DW'(1);
    localparam logic [DW-1:0]          PRE_LAST  = DW'(PRE_DELAY - 1);
    localparam logic [DW-1:0]          POS_LAST  = DW'(POS_DELAY - 1);
    localparam logic [TW-1:0]          TMO_ONE   = TW'(1);
    localparam logic [TW-1:0]          TMO_LAST  = TW'(CS_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_FILL = 3'd1,
        S_PRE_DELAY = 3'd2,
        S_INTR      = 3'd3,
        S_XFER      = 3'd4,
        S_DRAIN     = 3'd5,
        S_POS_DELAY = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic          cs_meta_q, cs_sync_q, cs_prev_q;
    logic          cs_fall, cs_rise;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d, cnt_next;
    logic [DW-1:0] dly_q, dly_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rd_en_q, rd_en_d;
    logic          intr_q, intr_d;
    logic          pkg_rdy_q, pkg_rdy_d;
    logic          pre_q, pre_d;
    logic          pos_q, pos_d;
    logic          busy_q, busy_d;
    logic [3:0]    err_q, err_d, err_set;

    // Two-flop synchroniser on raw chip select plus a history flop for edge detect.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cs_meta_q <= 1'b1;
            cs_sync_q <= 1'b1;
            cs_prev_q <= 1'b1;
        end else begin
            cs_meta_q <= cs_n;
            cs_sync_q <= cs_meta_q;
            cs_prev_q <= cs_sync_q;
        end
    end

    assign cs_fall = cs_prev_q & ~cs_sync_q;
    assign cs_rise = ~cs_prev_q & cs_sync_q;

    // Next-state, counter and error-event decode for the package FSM.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        dly_d      = dly_q;
        tmo_d      = tmo_q;
        rd_en_d    = 1'b0;
        pkg_rdy_d  = pkg_rdy_q;
        err_set    = 4'b0000;
        cnt_next   = byte_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_WAIT_FILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_FILL: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (fifo_level >= PKG_LEVEL) begin
                    state_d    = S_PRE_DELAY;
                    byte_cnt_d = '0;
                    dly_d      = '0;
                end else begin
                    state_d = S_WAIT_FILL;
                end
            end
            S_PRE_DELAY: begin
                if (dly_q == PRE_LAST) begin
                    state_d   = S_INTR;
                    tmo_d     = '0;
                    pkg_rdy_d = 1'b1;
                end else begin
                    dly_d = dly_q + DLY_ONE;
                end
            end
            S_INTR: begin
                if (cs_fall) begin
                    state_d = S_XFER;
                end else if (tmo_q == TMO_LAST) begin
                    // Package left in the FIFO; WAIT_FILL re-offers it.
                    state_d    = S_WAIT_FILL;
                    pkg_rdy_d  = 1'b0;
                    err_set[0] = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            S_XFER: begin
                if (byte_req) begin
                    if (byte_cnt_q == PKG_BYTES) begin
                        err_set[2] = 1'b1;
                    end else if (fifo_empty) begin
                        err_set[3] = 1'b1;
                    end else begin
                        rd_en_d = 1'b1;
                    end
                end else begin
                    rd_en_d = 1'b0;
                end
                // A read requested together with cs_rise counts before the length check.
                cnt_next   = rd_en_d ? (byte_cnt_q + BYTE_ONE) : byte_cnt_q;
                byte_cnt_d = cnt_next;
                if (cs_rise) begin
                    pkg_rdy_d = 1'b0;
                    dly_d     = '0;
                    if (cnt_next == PKG_BYTES) begin
                        state_d = S_POS_DELAY;
                    end else begin
                        state_d    = S_DRAIN;
                        err_set[1] = 1'b1;
                    end
                end else begin
                    state_d = S_XFER;
                end
            end
            S_DRAIN: begin
                if (byte_cnt_q == PKG_BYTES) begin
                    state_d = S_POS_DELAY;
                    dly_d   = '0;
                end else if (!fifo_empty) begin
                    rd_en_d    = 1'b1;
                    byte_cnt_d = byte_cnt_q + BYTE_ONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_POS_DELAY: begin
                if (dly_q == POS_LAST) begin
                    state_d = en ? S_WAIT_FILL : S_IDLE;
                end else begin
                    dly_d = dly_q + DLY_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered status outputs decoded from the next state; a set wins over err_clr.
    always_comb begin
        intr_d = (state_d == S_INTR);
        pre_d  = (state_d == S_PRE_DELAY);
        pos_d  = (state_d == S_POS_DELAY);
        busy_d = (state_d != S_IDLE) && (state_d != S_WAIT_FILL);
        err_d  = (err_clr ? 4'b0000 : err_q) | err_set;
    end

    // FSM, counters and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            dly_q      <= '0;
            tmo_q      <= '0;
            rd_en_q    <= 1'b0;
            intr_q     <= 1'b0;
            pkg_rdy_q  <= 1'b0;
            pre_q      <= 1'b0;
            pos_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 4'b0000;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            dly_q      <= dly_d;
            tmo_q      <= tmo_d;
            rd_en_q    <= rd_en_d;
            intr_q     <= intr_d;
            pkg_rdy_q  <= pkg_rdy_d;
            pre_q      <= pre_d;
            pos_q      <= pos_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

`ifdef SPI_PKG_CNT_EN
    logic [15:0] pkg_cnt_q, pkg_cnt_d;

    // Count a package when the post-delay expires (wraps at 16 bits).
    always_comb begin
        if ((state_q == S_POS_DELAY) && (dly_q == POS_LAST)) begin
            pkg_cnt_d = pkg_cnt_q + 16'd1;
        end else begin
            pkg_cnt_d = pkg_cnt_q;
        end
    end

    // Completed-package counter register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pkg_cnt_q <= 16'd0;
        end else begin
            pkg_cnt_q <= pkg_cnt_d;
        end
    end

    assign pkg_cnt = pkg_cnt_q;
`else
    assign pkg_cnt = 16'd0;
`endif

    assign fifo_rd_en     = rd_en_q;
    assign intr_out       = intr_q;
    assign package_ready  = pkg_rdy_q;
    assign pre_delay_flag = pre_q;
    assign pos_delay_flag = pos_q;
    assign busy           = busy_q;
    assign err_flags      = err_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_spi_pkg_ctrl.sv
// Self-checking bench for spi_pkg_ctrl. A byte-count FIFO model feeds the DUT;
// expected reads, sticky errors and package counts are derived per transfer from
// the number of byte requests issued in the chip-select window.
module tb_spi_pkg_ctrl;

    localparam int PKG = 10;
    localparam int PRE = 4;
    localparam int POS = 4;
    localparam int TMO = 100;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        en        = 1'b0;
    logic        cs_n      = 1'b1;
    logic        byte_req  = 1'b0;
    logic        err_clr   = 1'b0;
    logic [11:0] fifo_level;
    logic        fifo_empty;
    logic        fifo_rd_en, intr_out, package_ready, pre_delay_flag, pos_delay_flag, busy;
    logic [3:0]  err_flags;
    logic [15:0] pkg_cnt;
    logic [2:0]  state_dbg;

    int fill_total  = 0;
    int rd_total    = 0;
    int pre_total   = 0;
    int pos_total   = 0;
    bit empty_force = 1'b0;
    int fifo_cnt;

    int n_vec   = 0;
    int n_miss  = 0;
    int exp_err = 0;
    int exp_pkg = 0;

    spi_pkg_ctrl #(
        .PACKAGE_SIZE(PKG), .LEVEL_WIDTH(12), .PRE_DELAY(PRE),
        .POS_DELAY(POS), .CS_TIMEOUT(TMO)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en),
        .fifo_level(fifo_level), .fifo_empty(fifo_empty), .cs_n(cs_n),
        .byte_req(byte_req), .err_clr(err_clr), .fifo_rd_en(fifo_rd_en),
        .intr_out(intr_out), .package_ready(package_ready),
        .pre_delay_flag(pre_delay_flag), .pos_delay_flag(pos_delay_flag),
        .busy(busy), .err_flags(err_flags), .pkg_cnt(pkg_cnt), .state_dbg(state_dbg)
    );

    always #10 sys_clk = ~sys_clk;

    // FIFO occupancy = bytes written by the bench minus strobes seen.
    always_comb begin
        fifo_cnt   = fill_total - rd_total;
        fifo_level = (fifo_cnt <= 0) ? 12'd0 : 12'(fifo_cnt);
        fifo_empty = (fifo_cnt <= 0) || empty_force;
    end

    // Running totals of read strobes and delay-flag cycles.
    always @(posedge sys_clk) begin
        if (fifo_rd_en)     rd_total  <= rd_total + 1;
        if (pre_delay_flag) pre_total <= pre_total + 1;
        if (pos_delay_flag) pos_total <= pos_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_pkg_cnt(input string tag);
`ifdef SPI_PKG_CNT_EN
        check(tag, {16'd0, pkg_cnt}, exp_pkg);
`else
        check(tag, {16'd0, pkg_cnt}, 32'd0);
`endif
    endtask

    function automatic logic [31:0] all_outs();
        return {3'd0, fifo_rd_en, intr_out, package_ready, pre_delay_flag, pos_delay_flag,
                busy, err_flags, pkg_cnt, state_dbg};
    endfunction

    task automatic wait_intr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge sys_clk);
            if (intr_out) begin
                ok = 1'b1;
                break;
            end
        end
        check("intr_seen", {31'd0, ok}, 32'd1);
    endtask

    // One package offer: optional timeout first, then a cs window with n byte requests.
    task automatic run_pkg(input int n, input bit uf, input bit drop_en, input bit tmo, input bit filled);
        int p0, r0, q0, k;
        bit ok;
        en = 1'b1;
        p0 = pre_total;
        r0 = rd_total;
        if (!filled) fill_total += PKG;
        wait_intr(ok);
        if (!ok) return;
        check("pre_len", pre_total - p0, PRE);
        check("pkg_ready_on", {31'd0, package_ready}, 32'd1);
        if (tmo) begin
            k = 1;
            for (int i = 0; i < 300; i++) begin
                @(negedge sys_clk);
                if (!intr_out) break;
                k++;
            end
            exp_err |= 1;
            check("intr_len_tmo", k, TMO);
            check("state_tmo", {29'd0, state_dbg}, 32'd1);
            check("err_tmo", {28'd0, err_flags}, exp_err);
            check("pkg_ready_tmo", {31'd0, package_ready}, 32'd0);
            p0 = pre_total;
            wait_intr(ok);
            if (!ok) return;
            check("reoffer_pre", pre_total - p0, PRE);
        end
        cs_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("intr_hold", {31'd0, intr_out}, 32'd1);
        @(negedge sys_clk);
        check("intr_drop", {31'd0, intr_out}, 32'd0);
        check("state_xfer", {29'd0, state_dbg}, 32'd4);
        check("busy_xfer", {31'd0, busy}, 32'd1);
        if (drop_en) en = 1'b0;
        if (uf) begin
            empty_force = 1'b1;
            byte_req    = 1'b1;
            @(negedge sys_clk);
            byte_req    = 1'b0;
            empty_force = 1'b0;
            repeat (2) @(negedge sys_clk);
            check("uf_no_read", rd_total - r0, 0);
            exp_err |= 8;
        end
        for (int i = 0; i < n; i++) begin
            byte_req = 1'b1;
            @(negedge sys_clk);
            byte_req = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge sys_clk);
        end
        repeat (2) @(negedge sys_clk);
        check("reads_in_window", rd_total - r0, (n < PKG) ? n : PKG);
        q0   = pos_total;
        cs_n = 1'b1;
        if (n < PKG) exp_err |= 2;
        if (n > PKG) exp_err |= 4;
        exp_pkg = (exp_pkg + 1) & 16'hFFFF;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clk);
            if (state_dbg == (drop_en ? 3'd0 : 3'd1)) begin
                ok = 1'b1;
                break;
            end
        end
        check("end_state", {31'd0, ok}, 32'd1);
        check("reads_total", rd_total - r0, PKG);
        check("pos_len", pos_total - q0, POS);
        check("err_flags", {28'd0, err_flags}, exp_err);
        check("busy_end", {31'd0, busy}, 32'd0);
        check("pkg_ready_off", {31'd0, package_ready}, 32'd0);
        check_pkg_cnt("pkg_cnt");
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(negedge sys_clk);
        err_clr = 1'b0;
        exp_err = 0;
        check("err_clr", {28'd0, err_flags}, 32'd0);
    endtask

    initial begin
        bit ok;
        // Reset values.
        repeat (3) @(negedge sys_clk);
        check("reset_outs", all_outs(), 32'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("idle_no_en", {29'd0, state_dbg}, 32'd0);
        en = 1'b1;
        @(negedge sys_clk);
        check("wait_fill", {29'd0, state_dbg}, 32'd1);

        // Level boundary: 9 bytes holds, the 10th starts the pre-delay.
        fill_total += PKG - 1;
        repeat (5) @(negedge sys_clk);
        check("level9_state", {29'd0, state_dbg}, 32'd1);
        check("level9_pre", {31'd0, pre_delay_flag}, 32'd0);
        fill_total += 1;
        @(negedge sys_clk);
        check("level10_state", {29'd0, state_dbg}, 32'd2);
        run_pkg(PKG, 1'b0, 1'b0, 1'b0, 1'b1);

        // Directed cases: timeout, short, overrun, underflow, en drop.
        run_pkg(PKG, 1'b0, 1'b0, 1'b1, 1'b0);
        clear_errs();
        run_pkg(6, 1'b0, 1'b0, 1'b0, 1'b0);
        run_pkg(12, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_errs();
        run_pkg(PKG, 1'b1, 1'b0, 1'b0, 1'b0);
        clear_errs();
        run_pkg(PKG, 1'b0, 1'b1, 1'b0, 1'b0);

        // Randomised transfers.
        for (int it = 0; it < 10; it++) begin
            run_pkg($urandom_range(0, 14), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), 1'b0);
            if ($urandom_range(0, 1) == 1) clear_errs();
        end

        // Reset pulsed mid-transfer.
        en = 1'b1;
        fill_total += PKG;
        wait_intr(ok);
        cs_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        for (int i = 0; i < 3; i++) begin
            byte_req = 1'b1;
            @(negedge sys_clk);
            byte_req = 1'b0;
            @(negedge sys_clk);
        end
        sys_rst_n = 1'b0;
        #1;
        check("mid_reset_outs", all_outs(), 32'd0);
        cs_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        fill_total = rd_total;
        exp_err    = 0;
        exp_pkg    = 0;
        sys_rst_n  = 1'b1;
        @(negedge sys_clk);
        run_pkg(PKG, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
